// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and types for the RISC-V front end.
//               NOP_INSTR  - addi x0,x0,0, used as the IF/ID bubble payload
//               PC_STEP    - sequential fetch increment (one 32-bit word)
//               fetch_state_t - fetch-stage controller states
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register holding {pc, instr, valid}.
//               Flush has priority over enable and inserts a bubble while
//               leaving the PC field untouched.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               en_i          - capture pc_i/instr_i as a valid instruction
//               flush_i       - load bubble (valid=0, instr=NOP)
//               pc_i, instr_i - incoming fetch PC and instruction word
//               pc_o, instr_o, valid_o - register contents
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= 32'h0000_0000;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            // PC is intentionally kept: only the payload is squashed.
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (en_i) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            valid_q <= 1'b1;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Owns the PC, addresses a synchronous
//               instruction memory and feeds the IF/ID register.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               pc_w                - PC write enable (0 = stall PC)
//               pipeline_id_en      - IF/ID enable (0 = hold IF/ID)
//               branch_taken_ex     - redirect request from EX
//               branch_target_ex    - redirect target address
//               imem_addr           - instruction memory read address
//               imem_rdata          - word for address registered last edge
//               pc_id, instr_id, valid_id - IF/ID contents to decode
//               fetch_misaligned    - sticky misaligned-redirect error
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_w,
    input  logic        pipeline_id_en,
    input  logic        branch_taken_ex,
    input  logic [31:0] branch_target_ex,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        valid_id,
    output logic        fetch_misaligned
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_if_q;
    logic [31:0]  pc_next;
    logic         misaligned_q, misaligned_d;
    logic         target_aligned;
    logic         redirect_ok;
    logic         redirect_bad;
    logic         ifid_flush;
    logic         ifid_en;

    assign target_aligned = (branch_target_ex[1:0] == 2'b00);
    // HALT ignores redirects entirely; only reset leaves it.
    assign redirect_ok    = branch_taken_ex &&  target_aligned && (state_q != HALT);
    assign redirect_bad   = branch_taken_ex && !target_aligned && (state_q != HALT);

    // Next fetch address. imem_addr is driven from this so that pc_if_q
    // always names the word currently arriving on imem_rdata.
    always_comb begin
        pc_next = pc_if_q + PC_STEP;
        if (rst) begin
            pc_next = RESET_PC;
        end else if (state_q == HALT) begin
            pc_next = pc_if_q;
        end else if (redirect_ok) begin
            pc_next = branch_target_ex;
        end else if (redirect_bad) begin
            pc_next = pc_if_q;
        end else if (state_q == BOOT) begin
            pc_next = pc_if_q;
        end else if (!pc_w) begin
            pc_next = pc_if_q;
        end
    end

    assign imem_addr = pc_next;

    always_comb begin
        state_d      = state_q;
        misaligned_d = misaligned_q | redirect_bad;
        case (state_q)
            BOOT:    state_d = redirect_bad ? HALT : RUN;
            RUN:     state_d = redirect_bad ? HALT : RUN;
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_if_q      <= RESET_PC;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_if_q      <= pc_next;
            misaligned_q <= misaligned_d;
        end
    end

    // Any redirect outside HALT squashes the wrong-path word; capture only
    // happens in RUN because BOOT's word is re-read rather than consumed.
    assign ifid_flush = branch_taken_ex && (state_q != HALT);
    assign ifid_en    = pipeline_id_en && (state_q == RUN);

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .en_i    (ifid_en),
        .flush_i (ifid_flush),
        .pc_i    (pc_if_q),
        .instr_i (imem_rdata),
        .pc_o    (pc_id),
        .instr_o (instr_id),
        .valid_o (valid_id)
    );

    assign fetch_misaligned = misaligned_q;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Scoreboard bench for fetch_stage. Stimulus pushes expected
//               {pc_id, instr_id} captures; monitors pop on every new valid
//               IF/ID entry. Instruction memory word at address A is A>>2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_w;
    logic        pipeline_id_en;
    logic        branch_taken_ex;
    logic [31:0] branch_target_ex;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        valid_id;
    logic        fetch_misaligned;

    // Second instance exercising address wrap from a high reset vector.
    logic        rst2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic [31:0] pc_id2;
    logic [31:0] instr_id2;
    logic        valid_id2;
    logic        fetch_misaligned2;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_q  [$];
    logic [63:0] exp_q2 [$];

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_w             (pc_w),
        .pipeline_id_en   (pipeline_id_en),
        .branch_taken_ex  (branch_taken_ex),
        .branch_target_ex (branch_target_ex),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .pc_id            (pc_id),
        .instr_id         (instr_id),
        .valid_id         (valid_id),
        .fetch_misaligned (fetch_misaligned)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk              (clk),
        .rst              (rst2),
        .pc_w             (1'b1),
        .pipeline_id_en   (1'b1),
        .branch_taken_ex  (1'b0),
        .branch_target_ex (32'h0000_0000),
        .imem_addr        (imem_addr2),
        .imem_rdata       (imem_rdata2),
        .pc_id            (pc_id2),
        .instr_id         (instr_id2),
        .valid_id         (valid_id2),
        .fetch_misaligned (fetch_misaligned2)
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    always @(posedge clk) begin
        imem_rdata  <= memword(imem_addr);
        imem_rdata2 <= memword(imem_addr2);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc_id"},    pc_id,    32'h0);
        check({tag, "_instr_id"}, instr_id, 32'h13);
        check({tag, "_valid_id"}, {31'b0, valid_id}, 32'h0);
        check({tag, "_misalign"}, {31'b0, fetch_misaligned}, 32'h0);
        check({tag, "_imem_addr"}, imem_addr, 32'h0);
    endtask

    // Monitor: pops one expectation per newly presented valid IF/ID entry.
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc    = 32'h0;
    always @(negedge clk) begin
        if (valid_id === 1'b1 && (!prev_valid || pc_id !== prev_pc)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_capture_pc", pc_id, 32'hDEAD_BEEF);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("cap_pc", pc_id, e[63:32]);
                check("cap_instr", instr_id, e[31:0]);
            end
        end
        prev_valid = (valid_id === 1'b1);
        prev_pc    = pc_id;
    end

    logic        prev_valid2 = 1'b0;
    logic [31:0] prev_pc2    = 32'h0;
    always @(negedge clk) begin
        if (valid_id2 === 1'b1 && (!prev_valid2 || pc_id2 !== prev_pc2) && exp_q2.size() != 0) begin
            logic [63:0] e;
            e = exp_q2.pop_front();
            check("wrap_pc", pc_id2, e[63:32]);
            check("wrap_instr", instr_id2, e[31:0]);
        end
        prev_valid2 = (valid_id2 === 1'b1);
        prev_pc2    = pc_id2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        pc_w = 1'b1; pipeline_id_en = 1'b1;
        branch_taken_ex = 1'b0; branch_target_ex = 32'h0;

        exp_q2.push_back({32'hFFFF_FFF8, 32'h3FFF_FFFE});
        exp_q2.push_back({32'hFFFF_FFFC, 32'h3FFF_FFFF});
        exp_q2.push_back({32'h0000_0000, 32'h0000_0000});

        tick();
        check_reset_values("reset");
        rst = 1'b0; rst2 = 1'b0;
        #1;
        check("boot_imem_addr", imem_addr, 32'h0);

        exp_q.push_back({32'h0, 32'h0});
        exp_q.push_back({32'h4, 32'h1});
        exp_q.push_back({32'h8, 32'h2});
        tick();                                           // BOOT -> RUN
        check("boot_no_capture", {31'b0, valid_id}, 32'h0);
        check("run_imem_addr", imem_addr, 32'h4);
        tick();                                           // pc_id=0
        check("first_valid", {31'b0, valid_id}, 32'h1);
        tick();                                           // pc_id=4
        tick();                                           // pc_id=8

        // Two-cycle stall at pc_id=8.
        pc_w = 1'b0; pipeline_id_en = 1'b0;
        #1;
        check("stall_imem_addr", imem_addr, 32'hC);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_pc_id", pc_id, 32'h8);
            check("stall_instr_id", instr_id, 32'h2);
            check("stall_valid", {31'b0, valid_id}, 32'h1);
            check("stall_imem_addr_hold", imem_addr, 32'hC);
        end
        exp_q.push_back({32'hC, 32'h3});
        exp_q.push_back({32'h10, 32'h4});
        pc_w = 1'b1; pipeline_id_en = 1'b1;
        tick();                                           // pc_id=C
        tick();                                           // pc_id=10

        // Redirect to 0x100 while stalled.
        pc_w = 1'b0; pipeline_id_en = 1'b0;
        branch_taken_ex = 1'b1; branch_target_ex = 32'h100;
        #1;
        check("redirect_imem_addr", imem_addr, 32'h100);
        exp_q.push_back({32'h100, 32'h40});
        exp_q.push_back({32'h104, 32'h41});
        tick();
        branch_taken_ex = 1'b0;
        pc_w = 1'b1; pipeline_id_en = 1'b1;
        check("flush_valid", {31'b0, valid_id}, 32'h0);
        check("flush_instr", instr_id, 32'h13);
        check("flush_pc_keep", pc_id, 32'h10);
        tick();                                           // pc_id=100
        tick();                                           // pc_id=104, pc_if=108

        // Misaligned redirect.
        branch_taken_ex = 1'b1; branch_target_ex = 32'h102;
        #1;
        check("misalign_imem_addr", imem_addr, 32'h108);
        tick();
        branch_taken_ex = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("halt_misaligned", {31'b0, fetch_misaligned}, 32'h1);
            check("halt_valid", {31'b0, valid_id}, 32'h0);
            check("halt_imem_addr", imem_addr, 32'h108);
            tick();
        end
        // HALT must also ignore an aligned redirect.
        branch_taken_ex = 1'b1; branch_target_ex = 32'h200;
        #1;
        check("halt_ignore_redirect", imem_addr, 32'h108);
        branch_taken_ex = 1'b0;

        // Reset out of HALT.
        rst = 1'b1;
        tick();
        check_reset_values("reset_halt");
        rst = 1'b0;
        exp_q.push_back({32'h0, 32'h0});
        exp_q.push_back({32'h4, 32'h1});
        tick();                                           // BOOT -> RUN
        tick();                                           // pc_id=0
        tick();                                           // pc_id=4

        // Reset coinciding with a redirect.
        rst = 1'b1; branch_taken_ex = 1'b1; branch_target_ex = 32'h200;
        #1;
        check("rst_redirect_imem_addr", imem_addr, 32'h0);
        tick();
        check_reset_values("reset_mid");
        rst = 1'b0; branch_taken_ex = 1'b0;
        exp_q.push_back({32'h0, 32'h0});
        tick();
        check("reset_mid_boot_valid", {31'b0, valid_id}, 32'h0);
        tick();                                           // pc_id=0
        tick();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("wrap_scoreboard_drained", exp_q2.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
